enemy_missile_path: RTL and testbench

- Upstream stage of the enemy missile drawer.
- Flies one enemy missile from a spawn point on the top row (y=0) to a target x on the ground row, using integer Bresenham stepping: one pixel per game tick.
- Each new pixel is handed to the drawer as x/y/colour over a valid/ready handshake.
- Reports impact, or abort when the missile is destroyed.

---
 rtl/enemy_missile_path_pkg.sv | 32 +++
 rtl/enemy_missile_path_game_tick_gen.sv | 30 +++
 rtl/enemy_missile_path.sv | 164 ++++++++++++++++
 tb/tb_enemy_missile_path.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_missile_path_pkg.sv
// Shared constants and FSM state type for the enemy missile path stage.
// The state encoding is fixed by localparams so older code that compares raw
// 3-bit state values keeps working.
package enemy_missile_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int SCREEN_W = 160;
  localparam int GROUND_Y = 110;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;

  localparam logic [2:0] S_IDLE          = 3'd0;
  localparam logic [2:0] S_LOAD          = 3'd1;
  localparam logic [2:0] S_PRESENT       = 3'd2;
  localparam logic [2:0] S_WAIT_TICK     = 3'd3;
  localparam logic [2:0] S_STEP          = 3'd4;
  localparam logic [2:0] S_IMPACT        = 3'd5;
  localparam logic [2:0] S_PRESENT_ERASE = 3'd6;

  typedef enum logic [2:0] {
    IDLE          = S_IDLE,
    LOAD          = S_LOAD,
    PRESENT       = S_PRESENT,
    WAIT_TICK     = S_WAIT_TICK,
    STEP          = S_STEP,
    IMPACT        = S_IMPACT,
    PRESENT_ERASE = S_PRESENT_ERASE
  } state_t;

endpackage

// File: rtl/enemy_missile_path_game_tick_gen.sv
// Game tick generator: one-cycle tick every TICK_DIV clocks while enabled.
// Counter is held at zero while disabled so every enable starts a full period.
module game_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, cleared whenever the owner is idle
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/enemy_missile_path.sv
// Enemy missile path: flies one missile from (start_x,0) to (target_x,GROUND_Y)
// with Bresenham stepping, one pixel per game tick, handing each pixel to the
// drawer over a valid/ready handshake.
// Optional build macro ENEMY_MISSILE_ERASE_EN: before each step the previous
// pixel is re-presented in black, so the missile draws as a moving dot.
module enemy_missile_path #(
  parameter int         X_W            = enemy_missile_pkg::X_W,
  parameter int         Y_W            = enemy_missile_pkg::Y_W,
  parameter int         SCREEN_W       = enemy_missile_pkg::SCREEN_W,
  parameter int         GROUND_Y       = enemy_missile_pkg::GROUND_Y,
  parameter int         TICK_DIV       = 833333,
  parameter logic [2:0] MISSILE_COLOUR = enemy_missile_pkg::COL_RED
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           launch,
  input  logic [X_W-1:0] start_x,
  input  logic [X_W-1:0] target_x,
  input  logic           kill,
  input  logic           draw_ready,
  output logic           miss_valid,
  output logic [X_W-1:0] miss_x,
  output logic [Y_W-1:0] miss_y,
  output logic [2:0]     out_colour,
  output logic           active,
  output logic           impact,
  output logic [X_W-1:0] impact_x
);

  import enemy_missile_pkg::*;

  localparam int E_W = X_W + 2;
  localparam logic [X_W-1:0]        X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]        Y_GND = Y_W'(GROUND_Y);
  localparam logic signed [E_W-1:0] DY_E  = E_W'(GROUND_Y);
  localparam logic signed [E_W:0]   DY_S  = (E_W + 1)'(GROUND_Y);

  state_t                state;
  logic [X_W-1:0]        x, x_start, x_tgt, dx, dx_load;
  logic [Y_W-1:0]        y, y_n;
  logic [X_W-1:0]        x_n;
  logic                  dir_pos, pending, tick, at_ground;
  logic signed [E_W-1:0] err, err_load;
  logic signed [E_W:0]   err_w, e2, dx_s, err_n;

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (active),
    .tick (tick)
  );

  assign miss_valid = (state == PRESENT) || (state == PRESENT_ERASE);
  assign out_colour = (state == PRESENT) ? MISSILE_COLOUR : COL_BLACK;
  assign miss_x     = x;
  assign miss_y     = y;
  assign at_ground  = (x == x_tgt) && (y == Y_GND);

  // Initial line setup and one Bresenham iteration; both updates use the old err
  always_comb begin
    dx_load  = (x_tgt >= x_start) ? (x_tgt - x_start) : (x_start - x_tgt);
    err_load = $signed({2'b00, dx_load}) - DY_E;
    err_w    = {err[E_W-1], err};
    e2       = err_w <<< 1;
    dx_s     = {3'b000, dx};
    err_n    = err_w;
    x_n      = x;
    y_n      = y;
    if (e2 > -DY_S) begin
      err_n = err_n - DY_S;
      x_n   = dir_pos ? (x + X_W'(1)) : (x - X_W'(1));
    end
    if (e2 < dx_s) begin
      err_n = err_n + dx_s;
      y_n   = y + Y_W'(1);
    end
  end

  // Flight FSM, pending-tick flag and impact reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      x_start  <= '0;
      x_tgt    <= '0;
      dx       <= '0;
      dir_pos  <= 1'b0;
      err      <= '0;
      pending  <= 1'b0;
      active   <= 1'b0;
      impact   <= 1'b0;
      impact_x <= '0;
    end else begin
      impact <= 1'b0;
      if (tick && (state != WAIT_TICK)) pending <= 1'b1;
      if (kill && active) begin
        // a transfer in this same cycle has already completed at the drawer
        state   <= IDLE;
        active  <= 1'b0;
        pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (launch) begin
              x_start <= (start_x  >= X_MAX) ? X_MAX : start_x;
              x_tgt   <= (target_x >= X_MAX) ? X_MAX : target_x;
              active  <= 1'b1;
              pending <= 1'b0;
              state   <= LOAD;
            end
          end
          LOAD: begin
            x       <= x_start;
            y       <= '0;
            dx      <= dx_load;
            dir_pos <= (x_tgt >= x_start);
            err     <= err_load;
            state   <= PRESENT;
          end
          PRESENT: begin
            if (draw_ready) begin
              if (at_ground) begin
                impact   <= 1'b1;
                impact_x <= x;
                active   <= 1'b0;
                state    <= IMPACT;
              end else begin
                state <= WAIT_TICK;
              end
            end
          end
          WAIT_TICK: begin
            if (tick || pending) begin
              pending <= 1'b0;
`ifdef ENEMY_MISSILE_ERASE_EN
              state   <= PRESENT_ERASE;
`else
              state   <= STEP;
`endif
            end
          end
`ifdef ENEMY_MISSILE_ERASE_EN
          PRESENT_ERASE: begin
            if (draw_ready) state <= STEP;
          end
`endif
          STEP: begin
            x     <= x_n;
            y     <= y_n;
            err   <= err_n[E_W-1:0];
            state <= PRESENT;
          end
          IMPACT: begin
            pending <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enemy_missile_path.sv
// Self-checking bench for enemy_missile_path (GROUND_Y=10, TICK_DIV=2).
// Expected pixel streams come from an integer line model; a negedge monitor
// compares every presented pixel against the head of the expected stream.
module tb_enemy_missile_path;

  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int GROUND = 10;
  localparam int TDIV   = 2;
  localparam int SCREEN = 160;
  localparam int LIMIT  = 20000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] BLACK = 3'b000;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           launch = 1'b0;
  logic           kill = 1'b0;
  logic           draw_ready = 1'b0;
  logic [X_W-1:0] start_x = '0;
  logic [X_W-1:0] target_x = '0;
  logic           miss_valid, active, impact;
  logic [X_W-1:0] miss_x, impact_x;
  logic [Y_W-1:0] miss_y;
  logic [2:0]     out_colour;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_xfer = 0;
  int   flight_base = 0;
  int   ready_mode = 1;
  pix_t exp_q[$];
  pix_t mdl_q[$];
  logic exp_impact = 1'b0;
  logic [7:0] exp_ix = '0;
  logic stall_prev = 1'b0;
  logic kill_prev = 1'b0;

  enemy_missile_path #(
    .X_W            (X_W),
    .Y_W            (Y_W),
    .SCREEN_W       (SCREEN),
    .GROUND_Y       (GROUND),
    .TICK_DIV       (TDIV),
    .MISSILE_COLOUR (RED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .launch     (launch),
    .start_x    (start_x),
    .target_x   (target_x),
    .kill       (kill),
    .draw_ready (draw_ready),
    .miss_valid (miss_valid),
    .miss_x     (miss_x),
    .miss_y     (miss_y),
    .out_colour (out_colour),
    .active     (active),
    .impact     (impact),
    .impact_x   (impact_x)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic pix_t mk(input int x, input int y, input logic [2:0] c);
    pix_t p;
    p.x = 8'(x);
    p.y = 7'(y);
    p.c = c;
    return p;
  endfunction

  // Draw-ready driver: 0 = stall, 1 = always ready, 2 = random backpressure
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) draw_ready = ($urandom_range(0, 3) != 0);
    else draw_ready = (ready_mode == 1);
  end

  // Compare process: every presented pixel must be the next expected one
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      kill_prev  = 1'b0;
    end else begin
      if (stall_prev && !kill_prev) chk("hold_valid", 32'(miss_valid), 32'd1);
      if (miss_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_pixel: got (%0d,%0d,%0d) required no pixel", miss_x, miss_y, out_colour);
        end else begin
          chk("pixel", 32'({miss_x, miss_y, out_colour}), 32'(exp_q[0]));
          if (draw_ready) begin
            void'(exp_q.pop_front());
            n_xfer++;
          end
        end
      end
      if (impact) begin
        if (!exp_impact) begin
          n_chk++;
          $display("FAIL unexpected_impact: got impact=1 impact_x=%0d required impact=0", impact_x);
        end else begin
          chk("impact_x", 32'(impact_x), 32'(exp_ix));
          chk("impact_after_last_pixel", 32'(exp_q.size()), 32'd0);
          exp_impact = 1'b0;
        end
      end
      stall_prev = miss_valid && !draw_ready;
      kill_prev  = kill;
    end
  end

  // Line model: integer Bresenham from the clamped endpoints down to GROUND
  task automatic model_path(input int sx, input int tx);
    int cs, ct, x, y, dx, dy, s, err, e2, guard;
    cs = (sx >= SCREEN) ? SCREEN - 1 : sx;
    ct = (tx >= SCREEN) ? SCREEN - 1 : tx;
    x = cs; y = 0; dy = GROUND;
    dx = (ct >= cs) ? ct - cs : cs - ct;
    s = (ct >= cs) ? 1 : -1;
    err = dx - dy;
    guard = 0;
    mdl_q.delete();
    mdl_q.push_back(mk(x, y, RED));
    while (!(x == ct && y == dy) && guard < 1000) begin
`ifdef ENEMY_MISSILE_ERASE_EN
      mdl_q.push_back(mk(x, y, BLACK));
`endif
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += s; end
      if (e2 < dx) begin err += dx; y += 1; end
      mdl_q.push_back(mk(x, y, RED));
      guard++;
    end
  endtask

  // Pin the model against hand-derived paths: red pixel k must be at (fx(k), k)
  task automatic pin_model(input string name, input int sx, input int tx, input int kind);
    int bad, nred, nblk, ex, lx, ly;
    bad = 0; nred = 0; nblk = 0; lx = 0; ly = 0;
    model_path(sx, tx);
    foreach (mdl_q[i]) begin
      if (mdl_q[i].c == RED) begin
        case (kind)
          0: ex = sx;
          1: ex = nred;
          2: ex = 20 - nred;
          default: ex = nred / 2;
        endcase
        if (mdl_q[i] != mk(ex, nred, RED)) bad++;
        lx = ex; ly = nred;
        nred++;
      end else begin
        if (mdl_q[i] != mk(lx, ly, BLACK)) bad++;
        nblk++;
      end
    end
    chk({name, "_reds"}, 32'(nred), 32'd11);
    chk({name, "_bad"}, 32'(bad), 32'd0);
`ifdef ENEMY_MISSILE_ERASE_EN
    chk({name, "_erases"}, 32'(nblk), 32'd10);
`else
    chk({name, "_erases"}, 32'(nblk), 32'd0);
`endif
  endtask

  task automatic launch_flight(input int sx, input int tx);
    model_path(sx, tx);
    exp_q = mdl_q;
    exp_ix = 8'((tx >= SCREEN) ? SCREEN - 1 : tx);
    exp_impact = 1'b1;
    flight_base = n_xfer;
    @(posedge clk); #1;
    start_x = 8'(sx); target_x = 8'(tx); launch = 1'b1;
    @(posedge clk); #1;
    launch = 1'b0;
    start_x = 8'($urandom); target_x = 8'($urandom);
    @(negedge clk);
    chk("active_after_launch", 32'(active), 32'd1);
    chk("no_pixel_in_load", 32'(miss_valid), 32'd0);
    @(negedge clk);
    chk("first_pixel_latency", 32'(miss_valid), 32'd1);
  endtask

  task automatic wait_xfer(input int target);
    int n;
    n = 0;
    while (n_xfer < target && n < LIMIT) begin @(negedge clk); n++; end
    chk("xfer_reached", 32'(n_xfer >= target), 32'd1);
  endtask

  task automatic finish_flight();
    int n;
    n = 0;
    while (impact !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    chk("impact_seen", 32'(impact), 32'd1);
    chk("active_low_at_impact", 32'(active), 32'd0);
    @(negedge clk);
    chk("impact_one_cycle", 32'(impact), 32'd0);
    chk("impact_x_held", 32'(impact_x), 32'(exp_ix));
    exp_impact = 1'b0;
    exp_q.delete();
  endtask

  task automatic kill_flight(input int k);
    wait_xfer(flight_base + k);
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    exp_q.delete();
    exp_impact = 1'b0;
    @(negedge clk);
    chk("kill_active", 32'(active), 32'd0);
    chk("kill_valid", 32'(miss_valid), 32'd0);
    repeat (6) @(negedge clk);
    chk("kill_stays_idle", 32'({active, miss_valid}), 32'd0);
  endtask

  task automatic spurious_launch();
    @(posedge clk); #1;
    start_x = 8'($urandom); target_x = 8'($urandom); launch = 1'b1;
    @(posedge clk); #1;
    launch = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sx, tx, r, total;
    pin_model("pin_vertical", 50, 50, 0);
    pin_model("pin_diag_up", 0, 10, 1);
    pin_model("pin_diag_down", 20, 10, 2);
    pin_model("pin_half_slope", 0, 5, 3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({miss_valid, miss_x, miss_y, out_colour, active, impact, impact_x}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // kill while idle must be ignored
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("idle_kill_ignored", 32'({active, miss_valid, impact}), 32'd0);

    ready_mode = 1;
    launch_flight(50, 50);
    finish_flight();
    chk("vertical_impact_x", 32'(impact_x), 32'd50);

    launch_flight(0, 10);
    finish_flight();
    launch_flight(20, 10);
    finish_flight();
    chk("diag_down_impact_x", 32'(impact_x), 32'd10);

    // backpressure: 20 stalled cycles on the third pixel
    launch_flight(60, 60);
    wait_xfer(flight_base + 2);
    ready_mode = 0;
    begin
      int n;
      n = 0;
      while (!miss_valid && n < LIMIT) begin @(negedge clk); n++; end
      chk("stall_pixel_presented", 32'(miss_valid), 32'd1);
    end
    repeat (20) @(negedge clk);
    ready_mode = 1;
    finish_flight();

    // clamp plus an ignored relaunch mid-flight
    launch_flight(30, 200);
    wait_xfer(flight_base + 5);
    spurious_launch();
    finish_flight();
    chk("clamp_impact_x", 32'(impact_x), 32'd159);

    // kill while the fourth pixel is in flight
    launch_flight(10, 90);
    kill_flight(3);

    // reset mid-flight
    launch_flight(100, 40);
    wait_xfer(flight_base + 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midflight_reset_outputs", 32'({miss_valid, miss_x, miss_y, out_colour, active, impact, impact_x}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_impact = 1'b0;

    // randomized flights under random backpressure
    ready_mode = 2;
    repeat (12) begin
      sx = $urandom_range(0, 255);
      tx = $urandom_range(0, 255);
      r  = $urandom_range(0, 2);
      launch_flight(sx, tx);
      total = mdl_q.size();
      if (r == 0) begin
        kill_flight($urandom_range(1, total - 1));
      end else begin
        if (r == 1) begin
          wait_xfer(flight_base + 2);
          spurious_launch();
        end
        finish_flight();
      end
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
